// File: rtl/pipeline_hazard_unit_if.sv
// Decode-side bundle of the hazard unit: operand lookups and redirect come in,
// while forwarding selects, stall/flush controls and performance counters go out.
interface pipeline_hazard_unit_if #(
    parameter int XLEN          = 32,
    parameter int REGISTER_SIZE = 5,
    parameter int NUM_SRC       = 2,
    parameter int FWD_DEPTH     = 3
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                                    id_valid;
    logic [NUM_SRC-1:0][REGISTER_SIZE-1:0]   id_rs;
    logic [NUM_SRC-1:0]                      id_rs_used;
    logic [NUM_SRC-1:0][XLEN-1:0]            id_rf_data;
    logic                                    id_rd_we;
    logic [REGISTER_SIZE-1:0]                id_rd;
    logic                                    id_is_load;
    logic                                    redirect;
    logic [FWD_DEPTH-1:0][XLEN-1:0]          stage_data;

    logic [NUM_SRC-1:0][SEL_W-1:0]           fwd_sel;
    logic [NUM_SRC-1:0][XLEN-1:0]            fwd_data;
    logic                                    stall;
    logic                                    flush;
    logic [31:0]                             stall_count;
    logic [31:0]                             flush_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rf_data, id_rd_we, id_rd,
               id_is_load, redirect, stage_data,
        input  fwd_sel, fwd_data, stall, flush, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rf_data, id_rd_we, id_rd,
               id_is_load, redirect, stage_data,
        output fwd_sel, fwd_data, stall, flush, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Operand forwarding, load-use stall and redirect flush control for an in-order
// pipeline; tracks the destination of every in-flight instruction downstream of decode.
module pipeline_hazard_unit #(
    parameter int XLEN             = 32,
    parameter int REGISTER_SIZE    = 5,
    parameter int NUM_SRC          = 2,
    parameter int FWD_DEPTH        = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int FLUSH_CYCLES     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_unit_if.slave  hz
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [CNT_W-1:0]                       flush_cnt_q, flush_cnt_d;
    logic [31:0]                            stall_count_q, stall_count_d;
    logic [31:0]                            flush_count_q, flush_count_d;

    logic [FWD_DEPTH-1:0]                   ent_valid_q, ent_valid_d;
    logic [FWD_DEPTH-1:0]                   ent_we_q, ent_we_d;
    logic [FWD_DEPTH-1:0]                   ent_load_q, ent_load_d;
    logic [FWD_DEPTH-1:0][REGISTER_SIZE-1:0] ent_rd_q, ent_rd_d;

    logic [NUM_SRC-1:0][SEL_W-1:0]          sel;
    logic [NUM_SRC-1:0][XLEN-1:0]           sel_data;
    logic [NUM_SRC-1:0]                     src_load_use;
    logic                                   hazard;
    logic                                   flush_o;
    logic                                   stall_o;
    logic                                   issue;

    // Scan oldest to youngest so the youngest matching producer overwrites the result.
    always_comb begin
        sel          = '0;
        src_load_use = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
                if (ent_valid_q[i] && ent_we_q[i] && hz.id_rs_used[s] &&
                    (ent_rd_q[i] == hz.id_rs[s]) && (ent_rd_q[i] != '0)) begin
                    sel[s]          = SEL_W'(i + 1);
                    src_load_use[s] = ent_load_q[i] && (i < LOAD_READY_STAGE);
                end
            end
        end
    end

    always_comb begin
        sel_data = hz.id_rf_data;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                if (sel[s] == SEL_W'(i + 1)) begin
                    sel_data[s] = hz.stage_data[i];
                end
            end
        end
    end

    // A redirect kills decode, so it overrides any load-use stall in the same cycle.
    assign hazard  = hz.id_valid && (|src_load_use);
    assign flush_o = hz.redirect || (state_q == ST_FLUSH);
    assign stall_o = hazard && !flush_o;
    assign issue   = hz.id_valid && !stall_o && !flush_o;

    always_comb begin
        ent_valid_d = '0;
        ent_we_d    = '0;
        ent_load_d  = '0;
        ent_rd_d    = '0;
        for (int i = FWD_DEPTH - 1; i > 0; i--) begin
            ent_valid_d[i] = ent_valid_q[i-1];
            ent_we_d[i]    = ent_we_q[i-1];
            ent_load_d[i]  = ent_load_q[i-1];
            ent_rd_d[i]    = ent_rd_q[i-1];
        end
        ent_valid_d[0] = issue;
        ent_we_d[0]    = hz.id_rd_we;
        ent_load_d[0]  = hz.id_is_load;
        ent_rd_d[0]    = hz.id_rd;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.redirect) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: state_d = hazard ? ST_STALL : ST_RUN;
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_o && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (flush_o && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            ent_valid_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            ent_valid_q   <= ent_valid_d;
        end
    end

    // Payload fields are qualified by ent_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        ent_we_q   <= ent_we_d;
        ent_load_q <= ent_load_d;
        ent_rd_q   <= ent_rd_d;
    end

    assign hz.fwd_sel     = sel;
    assign hz.fwd_data    = sel_data;
    assign hz.stall       = stall_o;
    assign hz.flush       = flush_o;
    assign hz.stall_count = stall_count_q;
    assign hz.flush_count = flush_count_q;
endmodule
